ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  EX-stage multiply/divide unit owning the HI/LO registers. Sits directly downstream of the ID/EX pipeline register.
//  - Consumes the forwarded rs/rt operands and a decoded MD opcode for the instruction in EX.
//  - Models multi-cycle latency with a busy countdown; the hazard unit stalls ID on md_start|md_busy.
//  - mfhi/mflo read hi_out/lo_out combinationally, in the same cycle.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (and madd/maddu); must be >=1
//  DIV_CYCLES   10  busy cycles for div/divu; must be >=1
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high
//  md_op      in   4   decoded op of EX instr (mdu_pkg::md_op_e)
//  md_start   in   1   EX instr is mult/multu/div/divu(/madd/maddu); qualifies md_op
//  md_wr      in   1   EX instr is mthi/mtlo; qualifies md_op
//  rs_data    in   32  forwarded rs operand (dividend / multiplicand / mt source)
//  rt_data    in   32  forwarded rt operand (divisor / multiplier)
//  md_busy    out  1   operation in flight
//  hi_out     out  32  HI register
//  lo_out     out  32  LO register
// BEHAVIOUR
//  - Reset: md_busy=0, hi_out=0, lo_out=0, counter=0, state=IDLE. Reset mid-operation discards the result.
//  - FSM IDLE->BUSY: on md_start in IDLE at edge T0:
//    - latch the computed 64-bit result into shadow regs;
//    - load counter with MULT_CYCLES or DIV_CYCLES.
//  - BUSY: md_busy=1 for exactly N cycles (edges T0+1..T0+N). Counter decrements each edge.
//    - At the edge where counter 1->0: state->IDLE and shadow -> HI/LO. New HI/LO are visible in the same cycle md_busy falls.
//  - md_start while BUSY: ignored (hazard unit guarantees absence). md_start and md_wr both high: md_start wins.
//  - md_wr (mthi/mtlo) in IDLE: HI or LO <= rs_data at next edge. While BUSY: ignored.
//  - mult: signed 32x32 -> {HI,LO}. multu: unsigned.
//  - div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
//    - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  - divu: unsigned quotient/remainder.
//  - Divide by zero (rt_data==0): full DIV_CYCLES busy, HI/LO unchanged at completion.
//  - md_op values other than those listed, when qualified: no effect, no busy.
// CONFIGURATION
//  - MDU_MADD_EN defined: MD_MADD/MD_MADDU accepted with md_start.
//    - {HI,LO} <= {HI,LO} + rs*rt (signed/unsigned product, 64-bit wrap).
//    - Uses the HI/LO value at completion and MULT_CYCLES latency.
//  - MDU_MADD_EN undefined: MADD/MADDU treated as unlisted ops (no effect, no busy).
// STRUCTURE
//  - mdu_pkg: md_op_e enum
//    - MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8.
//    - also state enum {IDLE, BUSY} and default cycle constants.
//  - Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
//  - Sub-module mdu_arith: combinational 64-bit product/quotient/remainder from op and operands.
//    The top level holds the FSM, counter, shadow and HI/LO registers.
// TESTING
//  - mult rs=0xFFFFFFFF rt=2 -> busy 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE as busy falls.
//  - divu rs=7 rt=2 -> busy 10 cycles; then LO=3, HI=1.
//    div rs=0xFFFFFFF9 rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  - div rs=5 rt=0 with HI=0x11, LO=0x22 -> busy 10 cycles; HI=0x11, LO=0x22 unchanged.
//  - mthi rs=0xABCD in IDLE -> hi_out=0xABCD next cycle. mtlo during BUSY -> LO unaffected by the mt.
//  - reset asserted at cycle 4 of a div -> next cycle busy=0, HI=LO=0; no later update.
//  - MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, madd rs=1 rt=1 -> after 5 cycles HI=1, LO=0.
//    Without the macro: busy stays 0 and HI/LO unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// ============================================================================
// mdu_pkg : shared op/state encodings and default latencies for the MD unit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// ============================================================================
// mdu_arith : combinational 64-bit product / quotient / remainder generator
// Rev 1.0 : initial release (MDU_MADD_EN enables MADD/MADDU acceptance)
// ============================================================================
`default_nettype none

module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        accept,
  output logic        is_div,
  output logic        upd,
  output logic        acc,
  output logic [63:0] res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] rt_nz;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_u;
  logic [31:0] r_u;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  // Zero divisor is replaced so the dividers never see it; the result is dropped.
  assign rt_nz  = (rt == 32'd0) ? 32'd1 : rt;
  assign rs_mag = rs[31] ? (32'd0 - rs) : rs;
  assign rt_mag = rt_nz[31] ? (32'd0 - rt_nz) : rt_nz;
  assign q_mag  = rs_mag / rt_mag;
  assign r_mag  = rs_mag % rt_mag;
  assign q_u    = rs / rt_nz;
  assign r_u    = rs % rt_nz;

  always_comb begin
    accept = 1'b0;
    is_div = 1'b0;
    upd    = 1'b1;
    acc    = 1'b0;
    res    = 64'd0;
    case (md_op_e'(op))
      MD_MULT: begin
        accept = 1'b1;
        res    = prod_s;
      end
      MD_MULTU: begin
        accept = 1'b1;
        res    = prod_u;
      end
      MD_DIV: begin
        accept = 1'b1;
        is_div = 1'b1;
        upd    = (rt != 32'd0);
        res[63:32] = rs[31] ? (32'd0 - r_mag) : r_mag;
        res[31:0]  = (rs[31] ^ rt_nz[31]) ? (32'd0 - q_mag) : q_mag;
      end
      MD_DIVU: begin
        accept = 1'b1;
        is_div = 1'b1;
        upd    = (rt != 32'd0);
        res    = {r_u, q_u};
      end
`ifdef MDU_MADD_EN
      MD_MADD: begin
        accept = 1'b1;
        acc    = 1'b1;
        res    = prod_s;
      end
      MD_MADDU: begin
        accept = 1'b1;
        acc    = 1'b1;
        res    = prod_u;
      end
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// ex_muldiv_unit : EX-stage multiply/divide unit with HI/LO and busy countdown
// Rev 1.0 : initial release; define MDU_MADD_EN to accept MADD/MADDU
// ============================================================================
`default_nettype none

module ex_muldiv_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        md_start,
  input  logic        md_wr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        md_busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0] shadow_q, shadow_d;
  logic        upd_q, upd_d;
  logic        acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        a_accept;
  logic        a_is_div;
  logic        a_upd;
  logic        a_acc;
  logic [63:0] a_res;

  mdu_arith u_arith (
    .op     (md_op),
    .rs     (rs_data),
    .rt     (rt_data),
    .accept (a_accept),
    .is_div (a_is_div),
    .upd    (a_upd),
    .acc    (a_acc),
    .res    (a_res)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    upd_d    = upd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      ST_IDLE: begin
        // md_start takes precedence over md_wr even when its op is rejected.
        if (md_start) begin
          if (a_accept) begin
            state_d  = ST_BUSY;
            cnt_d    = a_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            shadow_d = a_res;
            upd_d    = a_upd;
            acc_d    = a_acc;
          end
        end else if (md_wr) begin
          if (md_op == MD_MTHI) hi_d = rs_data;
          if (md_op == MD_MTLO) lo_d = rs_data;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (upd_q) begin
            {hi_d, lo_d} = acc_q ? ({hi_q, lo_q} + shadow_q) : shadow_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= 64'd0;
      upd_q    <= 1'b0;
      acc_q    <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      upd_q    <= upd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign md_busy = (state_q == ST_BUSY);
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
// tb_ex_muldiv_unit : scoreboard bench for ex_muldiv_unit
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_ex_muldiv_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  md_op = 4'd0;
  logic        md_start = 1'b0;
  logic        md_wr = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        md_busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  ex_muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .md_start (md_start),
    .md_wr    (md_wr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .md_busy  (md_busy),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: a busy run ending without reset is a completed op; compare it.
  initial begin
    int   run = 0;
    logic rst_s;
    exp_t e;
    forever begin
      @(posedge clk);
      rst_s = reset;
      #1;
      if (md_busy === 1'b1) begin
        run++;
      end else begin
        if (run != 0 && !rst_s) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_completion", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk({e.name, "_busy_cycles"}, 32'(run), 32'(e.cyc));
            chk({e.name, "_hi"}, hi_out, e.hi);
            chk({e.name, "_lo"}, lo_out, e.lo);
          end
        end
        run = 0;
      end
    end
  end

  task automatic start_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    md_op = op; rs_data = rs; rt_data = rt; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0; md_op = MD_NONE;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40; i++) begin
      if (md_busy === 1'b0) break;
      @(negedge clk);
    end
    if (md_busy !== 1'b0) chk({name, "_timeout"}, 32'(md_busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int cyc, input logic [31:0] eh,
                        input logic [31:0] el);
    exp_t e;
    e.name = name; e.cyc = cyc; e.hi = eh; e.lo = el;
    exp_q.push_back(e);
    start_op(op, rs, rt);
    wait_idle(name);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    @(negedge clk);
    md_op = op; rs_data = v; md_wr = 1'b1;
    @(negedge clk);
    md_wr = 1'b0; md_op = MD_NONE;
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 32'(md_busy), 32'd0);
    chk("reset_hi", hi_out, 32'd0);
    chk("reset_lo", lo_out, 32'd0);

    run_op("mult_neg1x2", MD_MULT, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("divu_7_2", MD_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    mt(MD_MTHI, 32'h0000_ABCD);
    chk("mthi", hi_out, 32'h0000_ABCD);
    mt(MD_MTHI, 32'h11);
    mt(MD_MTLO, 32'h22);
    chk("mtlo", lo_out, 32'h22);

    run_op("div_by_zero", MD_DIV, 32'd5, 32'd0, 10, 32'h11, 32'h22);

    // mtlo while busy must not touch LO.
    e.name = "mult_3x4"; e.cyc = 5; e.hi = 32'd0; e.lo = 32'd12;
    exp_q.push_back(e);
    start_op(MD_MULT, 32'd3, 32'd4);
    mt(MD_MTLO, 32'hDEAD);
    chk("mtlo_while_busy", lo_out, 32'h22);
    wait_idle("mult_3x4");

    start_op(4'hF, 32'd9, 32'd9);
    chk("unlisted_busy", 32'(md_busy), 32'd0);
    chk("unlisted_lo", lo_out, 32'd12);

    mt(MD_MTHI, 32'd0);
    mt(MD_MTLO, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
    run_op("madd_1x1", MD_MADD, 32'd1, 32'd1, 5, 32'd1, 32'd0);
`else
    start_op(MD_MADD, 32'd1, 32'd1);
    chk("madd_off_busy", 32'(md_busy), 32'd0);
    @(negedge clk);
    chk("madd_off_hi", hi_out, 32'd0);
    chk("madd_off_lo", lo_out, 32'hFFFF_FFFF);
`endif

    // Reset in the fourth busy cycle of a divide discards its result.
    start_op(MD_DIVU, 32'd100, 32'd3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_busy", 32'(md_busy), 32'd0);
    chk("rst_mid_hi", hi_out, 32'd0);
    chk("rst_mid_lo", lo_out, 32'd0);
    repeat (15) @(negedge clk);
    chk("rst_mid_late_hi", hi_out, 32'd0);
    chk("rst_mid_late_lo", lo_out, 32'd0);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
